// File: rtl/sha3_dispatch_pkg.sv
// Shared types and helpers for the SHA-3 lane dispatcher.
// Holds the FSM state enum, the result FIFO entry struct and the lane slice shift function.
package sha3_dispatch_pkg;

    localparam int LANE_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_SCAN,
        ST_FINISH
    } dispatch_state_t;

    typedef struct packed {
        logic [31:0]           nonce;
        logic [LANE_IDX_W-1:0] lane;
    } res_entry_t;

    // Each lane owns an equal slice of the 32-bit nonce space.
    function automatic int lane_slice_shift(input int lanes);
        return 32 - $clog2(lanes);
    endfunction

endpackage

// File: rtl/sha3_result_fifo.sv
// Result FIFO for hit entries. It is a power-of-two depth ring buffer with a registered occupancy count.
// A push and a pop in the same cycle are both taken when the FIFO is full.
module sha3_result_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [31:0]
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   valid,
    output logic   full
);
    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sha3_lane_dispatcher.sv
// Dispatches a nonce scan across LANES scanner lanes and collects hits into a result FIFO.
// Hits are collected round-robin. Optional statistics counters are enabled with SHA3_DISPATCH_STATS_EN.
module sha3_lane_dispatcher
    import sha3_dispatch_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int RESULT_DEPTH = 4,
    localparam int LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            start_nonce,
    output logic                   ready,
    output logic                   dispatching,
    output logic                   evaluating,
    output logic                   done,
    output logic [LANES-1:0]       lane_start,
    output logic [LANES-1:0]       lane_abort,
    output logic [LANES-1:0][31:0] lane_nonce_base,
    input  logic [LANES-1:0]       lane_done,
    input  logic [LANES-1:0]       lane_found,
    input  logic [LANES-1:0][31:0] lane_nonce,
    output logic [LANES-1:0]       lane_ack,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_nonce,
    output logic [LW-1:0]          res_lane,
    output logic                   overflow
`ifdef SHA3_DISPATCH_STATS_EN
    ,
    output logic [31:0]            stat_cycles,
    output logic [15:0]            stat_hits
`endif
);
    localparam int            SHIFT     = lane_slice_shift(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    dispatch_state_t  state;
    logic [LW-1:0]    disp_idx;
    logic [LW-1:0]    rr_ptr;
    logic [LW-1:0]    grant_idx;
    logic [LANES-1:0] done_bits;
    logic             grant_vld;
    logic             grant_en;
    logic             do_abort;
    logic             all_done;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_valid;
    res_entry_t       push_entry;
    res_entry_t       head;

    assign ready       = (state == ST_IDLE);
    assign dispatching = (state == ST_DISPATCH);
    assign evaluating  = (state == ST_SCAN);
    assign do_abort    = abort && (state != ST_IDLE);
    assign done        = (state == ST_FINISH) && !abort;
    assign lane_abort  = {LANES{do_abort}};
    assign lane_start  = (dispatching && !abort) ? (LANES'(1) << disp_idx) : '0;
    assign all_done    = &(done_bits | lane_done);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop      = fifo_valid && res_ready;
    assign grant_en = !rst && !do_abort && (ready || !fifo_full || pop);

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= LANES; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % LANES;
            if (grant_en && !grant_vld && lane_found[j]) begin
                grant_vld = 1'b1;
                grant_idx = LW'(j);
            end
        end
    end

    assign lane_ack         = grant_vld ? (LANES'(1) << grant_idx) : '0;
    assign push             = grant_vld && !ready;
    assign push_entry.nonce = lane_nonce[grant_idx];
    assign push_entry.lane  = LANE_IDX_W'(grant_idx);

    sha3_result_fifo #(
        .DEPTH   (RESULT_DEPTH),
        .entry_t (res_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid),
        .full      (fifo_full)
    );

    assign res_valid = fifo_valid;
    assign res_nonce = fifo_valid ? head.nonce : '0;
    assign res_lane  = fifo_valid ? LW'(head.lane) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            disp_idx        <= '0;
            rr_ptr          <= '0;
            done_bits       <= '0;
            overflow        <= 1'b0;
            lane_nonce_base <= '0;
        end else begin
            if (grant_vld)
                rr_ptr <= grant_idx;
            // Hits arriving while idle have no scan to belong to and are dropped.
            if (grant_vld && ready)
                overflow <= 1'b1;
            if (dispatching || evaluating)
                done_bits <= done_bits | lane_done;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_DISPATCH;
                        disp_idx  <= '0;
                        done_bits <= '0;
                        for (int i = 0; i < LANES; i++)
                            lane_nonce_base[i] <= start_nonce + 32'(64'(i) << SHIFT);
                    end
                end
                ST_DISPATCH: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        disp_idx <= disp_idx + 1'b1;
                        if (disp_idx == LAST_LANE)
                            state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (abort)
                        state <= ST_IDLE;
                    else if (all_done && !(|lane_found))
                        state <= ST_FINISH;
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

`ifdef SHA3_DISPATCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cycles <= '0;
            stat_hits   <= '0;
        end else if (ready && start) begin
            stat_cycles <= '0;
            stat_hits   <= '0;
        end else begin
            if (!ready && stat_cycles != '1)
                stat_cycles <= stat_cycles + 1'b1;
            if (push && stat_hits != '1)
                stat_hits <= stat_hits + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sha3_lane_dispatcher.sv
// Directed scoreboard bench for sha3_lane_dispatcher (LANES=4, RESULT_DEPTH=4).
// Lanes hold lane_found until acked; the result FIFO output is compared in order against expected entries.
module tb_sha3_lane_dispatcher;

    typedef struct {
        logic [31:0] nonce;
        logic [1:0]  lane;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, start, abort, res_ready;
    logic [31:0]      start_nonce;
    logic             ready, dispatching, evaluating, done, overflow, res_valid;
    logic [3:0]       lane_start, lane_abort, lane_done, lane_found, lane_ack;
    logic [3:0][31:0] lane_nonce_base, lane_nonce;
    logic [31:0]      res_nonce;
    logic [1:0]       res_lane;
`ifdef SHA3_DISPATCH_STATS_EN
    logic [31:0]      stat_cycles;
    logic [15:0]      stat_hits;
`endif

    int         checks = 0;
    int         errors = 0;
    int         ack_count = 0;
    logic [3:0] pend_ack;
    exp_t       exp_q[$];
    exp_t       obs_q[$];

    sha3_lane_dispatcher #(.LANES(4), .RESULT_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .start_nonce(start_nonce),
        .ready(ready), .dispatching(dispatching), .evaluating(evaluating), .done(done),
        .lane_start(lane_start), .lane_abort(lane_abort), .lane_nonce_base(lane_nonce_base),
        .lane_done(lane_done), .lane_found(lane_found), .lane_nonce(lane_nonce),
        .lane_ack(lane_ack), .res_valid(res_valid), .res_ready(res_ready),
        .res_nonce(res_nonce), .res_lane(res_lane), .overflow(overflow)
`ifdef SHA3_DISPATCH_STATS_EN
        , .stat_cycles(stat_cycles), .stat_hits(stat_hits)
`endif
    );

    always #5 clk = ~clk;

    // Sample what the coming edge will register, advance one cycle, and let acked lanes drop found.
    task automatic cycle();
        exp_t e;
        #1;
        pend_ack = lane_ack;
        ack_count += $countones(lane_ack);
        if (res_valid && res_ready) begin
            e.nonce = res_nonce;
            e.lane  = res_lane;
            obs_q.push_back(e);
        end
        @(posedge clk);
        #1;
        lane_found = lane_found & ~pend_ack;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
        lane_done = '0; lane_found = '0; lane_nonce = '0; start_nonce = '0;
        cycle();
        cycle();
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic start_scan(input logic [31:0] n);
        start_nonce = n;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic drain(input int want, input int budget);
        res_ready = 1'b1;
        for (int c = 0; c < budget && obs_q.size() < want; c++) cycle();
    endtask

    task automatic finish_scan();
        int c;
        c = 0;
        lane_done = '1;
        cycle();
        lane_done = '0;
        while (!ready && c < 10) begin
            cycle();
            c++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL finish_ready: got %b expected 1", ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
        lane_done = '0; lane_nonce = '0; start_nonce = '0;
        lane_found = 4'b0101;
        cycle();
        checks++;
        if ({ready, dispatching, evaluating, done, overflow, res_valid} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {ready, dispatching, evaluating, done, overflow, res_valid});
        end
        checks++;
        if ({lane_start, lane_abort, lane_ack} !== 12'h000) begin
            errors++;
            $display("FAIL reset_lane_ctl: got %h expected 000", {lane_start, lane_abort, lane_ack});
        end
        checks++;
        if (lane_nonce_base !== 128'h0 || res_nonce !== 32'h0 || res_lane !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%0d expected 0", lane_nonce_base, res_nonce, res_lane);
        end
        lane_found = '0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_nonce_bases();
        do_reset();
        start_nonce = 32'hF000_0000;
        start = 1'b1;
        abort = 1'b1;
        #1;
        checks++;
        if (lane_abort !== 4'b0000) begin
            errors++;
            $display("FAIL idle_abort: got %b expected 0000", lane_abort);
        end
        cycle();
        start = 1'b0;
        abort = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cycle();
            checks++;
            if (lane_start !== (4'b0001 << k) || dispatching !== 1'b1) begin
                errors++;
                $display("FAIL lane_start_%0d: got %b/%b expected %b/1", k, lane_start, dispatching,
                         4'b0001 << k);
            end
        end
        cycle();
        checks++;
        if (evaluating !== 1'b1 || lane_start !== 4'b0000) begin
            errors++;
            $display("FAIL scan_entry: got %b/%b expected 1/0000", evaluating, lane_start);
        end
        checks++;
        if (lane_nonce_base !== {32'hB000_0000, 32'h7000_0000, 32'h3000_0000, 32'hF000_0000}) begin
            errors++;
            $display("FAIL nonce_bases: got %h expected b000000070000000300000000f0000000",
                     lane_nonce_base);
        end
    endtask

    task automatic test_completion();
        lane_done = 4'b0111;
        cycle();
        lane_done = 4'b1000;
        checks++;
        if (done !== 1'b0 || evaluating !== 1'b1) begin
            errors++;
            $display("FAIL early_done: got %b/%b expected 0/1", done, evaluating);
        end
        cycle();
        lane_done = '0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: got %b expected 1", done);
        end
        cycle();
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_done: got %b/%b expected 1/0", ready, done);
        end
        checks++;
        if (lane_nonce_base[1] !== 32'h3000_0000) begin
            errors++;
            $display("FAIL base_hold: got %h expected 30000000", lane_nonce_base[1]);
        end
    endtask

    task automatic test_hits();
        exp_t e, o;
        do_reset();
        start_scan(32'h0);
        lane_nonce[1] = 32'h11;
        lane_nonce[3] = 32'h33;
        lane_found = 4'b1010;
        exp_q.push_back('{32'h11, 2'd1});
        exp_q.push_back('{32'h33, 2'd3});
        #1;
        checks++;
        if (lane_ack !== 4'b0010 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL hit_ack1: got %b/%b expected 0010/0", lane_ack, res_valid);
        end
        cycle();
        checks++;
        if (lane_ack !== 4'b1000 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL hit_ack2: got %b/%b expected 1000/1", lane_ack, res_valid);
        end
        cycle();
        checks++;
        if (lane_ack !== 4'b0000) begin
            errors++;
            $display("FAIL hit_ack_idle: got %b expected 0000", lane_ack);
        end
        drain(2, 20);
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL hit_count: got %0d expected 2", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.nonce !== e.nonce || o.lane !== e.lane) begin
                errors++;
                $display("FAIL hit_entry: got (%h,%0d) expected (%h,%0d)", o.nonce, o.lane, e.nonce, e.lane);
            end
        end
        finish_scan();
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        do_reset();
        start_scan(32'h1234_5678);
        lane_nonce = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        lane_found = 4'b1111;
        exp_q.push_back('{32'hA1, 2'd1});
        exp_q.push_back('{32'hA2, 2'd2});
        exp_q.push_back('{32'hA3, 2'd3});
        exp_q.push_back('{32'hA0, 2'd0});
        ack_count = 0;
        repeat (4) cycle();
        checks++;
        if (ack_count != 4) begin
            errors++;
            $display("FAIL bp_first_acks: got %0d expected 4", ack_count);
        end
        lane_nonce[1] = 32'hB1;
        lane_nonce[2] = 32'hB2;
        lane_found = 4'b0110;
        exp_q.push_back('{32'hB1, 2'd1});
        exp_q.push_back('{32'hB2, 2'd2});
        ack_count = 0;
        repeat (3) begin
            #1;
            checks++;
            if (lane_ack !== 4'b0000) begin
                errors++;
                $display("FAIL bp_stall_ack: got %b expected 0000", lane_ack);
            end
            cycle();
        end
        checks++;
        if (ack_count != 0 || overflow !== 1'b0 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: got acks=%0d ovf=%b vld=%b expected 0/0/1", ack_count, overflow, res_valid);
        end
        drain(6, 40);
        checks++;
        if (obs_q.size() != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 6", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.nonce !== e.nonce || o.lane !== e.lane) begin
                errors++;
                $display("FAIL bp_entry: got (%h,%0d) expected (%h,%0d)", o.nonce, o.lane, e.nonce, e.lane);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_overflow: got %b expected 0", overflow);
        end
        finish_scan();
    endtask

    task automatic test_abort();
        exp_t e, o;
        logic saw_done;
        do_reset();
        start_scan(32'h0);
        lane_nonce[0] = 32'hC0;
        lane_nonce[2] = 32'hC2;
        lane_found = 4'b0101;
        exp_q.push_back('{32'hC2, 2'd2});
        exp_q.push_back('{32'hC0, 2'd0});
        ack_count = 0;
        repeat (2) cycle();
        checks++;
        if (ack_count != 2) begin
            errors++;
            $display("FAIL abort_queue: got %0d acks expected 2", ack_count);
        end
        abort = 1'b1;
        #1;
        checks++;
        if (lane_abort !== 4'b1111 || done !== 1'b0 || lane_ack !== 4'b0000) begin
            errors++;
            $display("FAIL abort_pulse: got %b/%b/%b expected 1111/0/0000", lane_abort, done, lane_ack);
        end
        cycle();
        abort = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || lane_abort !== 4'b0000) begin
            errors++;
            $display("FAIL abort_idle: got %b/%b expected 1/0000", ready, lane_abort);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            saw_done |= done;
            cycle();
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got %b expected 0", saw_done);
        end
        drain(2, 20);
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL abort_count: got %0d expected 2", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.nonce !== e.nonce || o.lane !== e.lane) begin
                errors++;
                $display("FAIL abort_entry: got (%h,%0d) expected (%h,%0d)", o.nonce, o.lane, e.nonce, e.lane);
            end
        end
        lane_nonce[2] = 32'hDD;
        lane_found = 4'b0100;
        #1;
        checks++;
        if (lane_ack !== 4'b0100) begin
            errors++;
            $display("FAIL idle_ack: got %b expected 0100", lane_ack);
        end
        cycle();
        checks++;
        if (overflow !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_discard: got ovf=%b vld=%b expected 1/0", overflow, res_valid);
        end
    endtask

    task automatic test_reset_midscan();
        do_reset();
        start_scan(32'h5555_0000);
        checks++;
        if (evaluating !== 1'b1) begin
            errors++;
            $display("FAIL midscan_state: got %b expected 1", evaluating);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ready, evaluating, dispatching, done} !== 4'b1000 || lane_abort !== 4'b0000 ||
            lane_nonce_base !== 128'h0) begin
            errors++;
            $display("FAIL midscan_reset: got %b/%b/%h expected 1000/0000/0",
                     {ready, evaluating, dispatching, done}, lane_abort, lane_nonce_base);
        end
        cycle();
        checks++;
        if (lane_abort !== 4'b0000 || ready !== 1'b1) begin
            errors++;
            $display("FAIL midscan_hold: got %b/%b expected 0000/1", lane_abort, ready);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        res_ready = 1'b0;
        lane_done = '0;
        lane_found = '0;
        lane_nonce = '0;
        start_nonce = '0;
        pend_ack = '0;
        test_reset();
        test_nonce_bases();
        test_completion();
        test_hits();
        test_back_to_back();
        test_abort();
        test_reset_midscan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
